// File: rtl/softmc_app_endpoint.sv
// SoftMC host-bridge endpoint: instruction FIFO from the PCIe application to the
// DRAM command sequencer, and a FWFT readback FIFO collecting DDR read bursts.

module softmc_sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full
);
   localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

   logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;

   // push/pop arrive already qualified by the owner; pointers wrap naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   // storage is never reset; a write during reset lands in a slot that is discarded
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = empty_q;
   assign full  = full_q;
endmodule

module softmc_app_endpoint #(
   parameter int DQ_WIDTH         = 64,
   parameter int INSTR_DEPTH_LOG2 = 4,
   parameter int RDBK_DEPTH_LOG2  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         app_en,
   input  logic [31:0]                  app_instr,
   output logic                         app_ack,
   output logic                         instr_valid,
   output logic [31:0]                  instr_data,
   input  logic                         instr_ready,
   input  logic                         rd_valid,
   input  logic [DQ_WIDTH*4-1:0]        rd_data,
   output logic                         rdback_fifo_empty,
   input  logic                         rdback_fifo_rden,
   output logic [DQ_WIDTH*4-1:0]        rdback_data,
   output logic [INSTR_DEPTH_LOG2:0]    instr_count,
   output logic [RDBK_DEPTH_LOG2:0]     rdback_count,
   output logic                         rdback_overflow
);
   logic instr_empty, instr_full, instr_push, instr_pop;
   logic rb_empty, rb_full, rb_push, rb_pop;
   logic overflow_q, overflow_d;

   // full blocks the push even when a pop happens in the same cycle
   assign app_ack    = app_en && !instr_full;
   assign instr_push = app_ack;
   assign instr_pop  = instr_ready && !instr_empty;

   softmc_sync_fifo #(
      .WIDTH      (32),
      .DEPTH_LOG2 (INSTR_DEPTH_LOG2)
   ) u_instr_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (instr_push),
      .pop   (instr_pop),
      .wdata (app_instr),
      .rdata (instr_data),
      .count (instr_count),
      .empty (instr_empty),
      .full  (instr_full)
   );

   // the PHY cannot stall: a burst is kept if a slot exists or one frees this cycle
   assign rb_pop  = rdback_fifo_rden && !rb_empty;
   assign rb_push = rd_valid && (!rb_full || rb_pop);

   softmc_sync_fifo #(
      .WIDTH      (DQ_WIDTH*4),
      .DEPTH_LOG2 (RDBK_DEPTH_LOG2)
   ) u_rdbk_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rb_push),
      .pop   (rb_pop),
      .wdata (rd_data),
      .rdata (rdback_data),
      .count (rdback_count),
      .empty (rb_empty),
      .full  (rb_full)
   );

   always_comb begin
      overflow_d = overflow_q;
      if (rd_valid && !rb_push) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

   assign instr_valid       = !instr_empty;
   assign rdback_fifo_empty = rb_empty;
   assign rdback_overflow   = overflow_q;
endmodule

// File: tb/tb_softmc_app_endpoint.sv
// Randomized and directed bench for softmc_app_endpoint against a queue-based model.

module tb_softmc_app_endpoint;
   localparam int DQ_WIDTH = 64;
   localparam int RW       = DQ_WIDTH*4;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, app_en, app_ack, instr_valid, instr_ready;
   logic          rd_valid, rdback_fifo_empty, rdback_fifo_rden, rdback_overflow;
   logic [31:0]   app_instr, instr_data;
   logic [RW-1:0] rd_data, rdback_data;
   logic [4:0]    instr_count, rdback_count;

   softmc_app_endpoint #(
      .DQ_WIDTH         (DQ_WIDTH),
      .INSTR_DEPTH_LOG2 (4),
      .RDBK_DEPTH_LOG2  (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .app_en            (app_en),
      .app_instr         (app_instr),
      .app_ack           (app_ack),
      .instr_valid       (instr_valid),
      .instr_data        (instr_data),
      .instr_ready       (instr_ready),
      .rd_valid          (rd_valid),
      .rd_data           (rd_data),
      .rdback_fifo_empty (rdback_fifo_empty),
      .rdback_fifo_rden  (rdback_fifo_rden),
      .rdback_data       (rdback_data),
      .instr_count       (instr_count),
      .rdback_count      (rdback_count),
      .rdback_overflow   (rdback_overflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0]   iq[$];
   logic [RW-1:0] rq[$];
   bit            ovf;
   bit            ack;
   logic [31:0]   nxt;

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] rnd_word();
      logic [RW-1:0] v;
      v = '0;
      for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_all();
      chk("app_ack", RW'(app_ack), RW'(app_en && (iq.size() < DEPTH)));
      chk("instr_valid", RW'(instr_valid), RW'(iq.size() != 0));
      chk("instr_count", RW'(instr_count), RW'(iq.size()));
      if (iq.size() != 0) chk("instr_data", RW'(instr_data), RW'(iq[0]));
      chk("rdback_empty", RW'(rdback_fifo_empty), RW'(rq.size() == 0));
      chk("rdback_count", RW'(rdback_count), RW'(rq.size()));
      if (rq.size() != 0) chk("rdback_data", rdback_data, rq[0]);
      chk("overflow", RW'(rdback_overflow), RW'(ovf));
   endtask

   // Called just after a falling edge: drive, check, advance model across the rising edge.
   task automatic cyc(input bit r, input bit en, input logic [31:0] ins, input bit rdy,
                      input bit rv, input logic [RW-1:0] rdd, input bit rden, output bit acked);
      bit ipop, rpop, rpush;
      rst = r; app_en = en; app_instr = ins; instr_ready = rdy;
      rd_valid = rv; rd_data = rdd; rdback_fifo_rden = rden;
      #1;
      check_all();
      acked = en && (iq.size() < DEPTH);
      ipop  = rdy && (iq.size() != 0);
      rpop  = rden && (rq.size() != 0);
      rpush = rv && ((rq.size() < DEPTH) || rpop);
      @(posedge clk);
      if (r) begin
         iq.delete(); rq.delete(); ovf = 1'b0;
      end else begin
         if (ipop) void'(iq.pop_front());
         if (acked) iq.push_back(ins);
         if (rpop) void'(rq.pop_front());
         if (rpush) rq.push_back(rdd);
         else if (rv) ovf = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      cyc(1, 0, 32'h0, 0, 0, '0, 0, ack);
   endtask

   initial begin
      logic [RW-1:0] da, db;
      da = {64{4'hA}};
      db = {64{4'hB}};
      rst = 1; app_en = 0; app_instr = 0; instr_ready = 0;
      rd_valid = 0; rd_data = '0; rdback_fifo_rden = 0;
      @(posedge clk); @(negedge clk);
      iq.delete(); rq.delete(); ovf = 0;
      do_reset();

      // three pushes, no pops
      for (int k = 1; k <= 3; k++) cyc(0, 1, 32'(k), 0, 0, '0, 0, ack);
      #1;
      chk("tp1_count", RW'(instr_count), RW'(3));
      chk("tp1_head", RW'(instr_data), RW'(32'h1));

      // fill to 16, 17th back-pressured until a pop frees a slot
      do_reset();
      nxt = 1;
      for (int k = 0; k < 17; k++) begin
         cyc(0, 1, nxt, 0, 0, '0, 0, ack);
         if (ack) nxt++;
      end
      chk("fill_count", RW'(instr_count), RW'(16));
      chk("fill_nxt", RW'(nxt), RW'(17));
      cyc(0, 1, nxt, 1, 0, '0, 0, ack);
      chk("fill_ack_at_full", RW'(ack), RW'(0));
      cyc(0, 1, nxt, 0, 0, '0, 0, ack);
      chk("fill_ack_after_pop", RW'(ack), RW'(1));
      for (int k = 0; k < 17; k++) cyc(0, 0, 32'h0, 1, 0, '0, 0, ack);
      #1;
      chk("fill_drained", RW'(instr_count), RW'(0));

      // simultaneous push/pop at count 5 across pointer wrap
      do_reset();
      nxt = 32'h100;
      for (int k = 0; k < 5; k++) begin cyc(0, 1, nxt, 0, 0, '0, 0, ack); nxt++; end
      for (int k = 0; k < 20; k++) begin cyc(0, 1, nxt, 1, 0, '0, 0, ack); nxt++; end
      #1;
      chk("pp_count", RW'(instr_count), RW'(5));
      chk("pp_head", RW'(instr_data), RW'(32'h114));

      // readback FWFT
      do_reset();
      cyc(0, 0, 32'h0, 0, 1, da, 0, ack);
      #1;
      chk("rb_first_empty", RW'(rdback_fifo_empty), RW'(0));
      cyc(0, 0, 32'h0, 0, 1, db, 0, ack);
      #1;
      chk("rb_head_a", rdback_data, da);
      cyc(0, 0, 32'h0, 0, 0, '0, 1, ack);
      #1;
      chk("rb_head_b", rdback_data, db);
      cyc(0, 0, 32'h0, 0, 0, '0, 1, ack);
      #1;
      chk("rb_empty_after", RW'(rdback_fifo_empty), RW'(1));

      // overflow and stickiness
      do_reset();
      for (int k = 0; k < 17; k++) cyc(0, 0, 32'h0, 0, 1, rnd_word(), 0, ack);
      #1;
      chk("ovf_count", RW'(rdback_count), RW'(16));
      chk("ovf_flag", RW'(rdback_overflow), RW'(1));
      for (int k = 0; k < 16; k++) cyc(0, 0, 32'h0, 0, 0, '0, 1, ack);
      #1;
      chk("ovf_sticky", RW'(rdback_overflow), RW'(1));
      do_reset();
      #1;
      chk("ovf_cleared", RW'(rdback_overflow), RW'(0));

      // reset mid-stream with both FIFOs at 7, then empty pops
      for (int k = 0; k < 7; k++) cyc(0, 1, 32'h200 + 32'(k), 0, 1, rnd_word(), 0, ack);
      #1;
      chk("mid_icount", RW'(instr_count), RW'(7));
      cyc(1, 1, 32'h2FF, 0, 1, rnd_word(), 0, ack);
      #1;
      chk("mid_icount0", RW'(instr_count), RW'(0));
      chk("mid_rcount0", RW'(rdback_count), RW'(0));
      chk("mid_ivalid", RW'(instr_valid), RW'(0));
      chk("mid_rempty", RW'(rdback_fifo_empty), RW'(1));
      cyc(0, 0, 32'h0, 1, 0, '0, 1, ack);
      cyc(0, 0, 32'h0, 1, 0, '0, 1, ack);
      cyc(0, 1, 32'h300, 0, 1, da, 0, ack);
      #1;
      chk("empty_pop_idata", RW'(instr_data), RW'(32'h300));
      chk("empty_pop_rdata", rdback_data, da);

      // randomized traffic with occasional resets
      nxt = 32'h1000;
      for (int k = 0; k < 3000; k++) begin
         bit r, en, rdy, rv, rden;
         r    = ($urandom_range(0, 299) == 0);
         en   = ($urandom_range(0, 99) < 60);
         rdy  = ($urandom_range(0, 99) < ((k / 500) % 2 ? 70 : 35));
         rv   = ($urandom_range(0, 99) < 55);
         rden = ($urandom_range(0, 99) < ((k / 400) % 2 ? 70 : 30));
         cyc(r, en, nxt, rdy, rv, rnd_word(), rden, ack);
         if (ack) nxt++;
      end
      #1;
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/softmc_app_endpoint.md
# softmc_app_endpoint

Memory-controller-side endpoint of the SoftMC host bridge. Accepts the 32-bit instruction stream from the PCIe application over the `app_en`/`app_ack` handshake, buffers it in an instruction FIFO for the DRAM command sequencer, and collects DDR read-burst data into a first-word-fall-through readback FIFO that the PCIe application drains through `rdback_fifo_empty`/`rdback_fifo_rden`/`rdback_data`. It sits between the PCIe application and the sequencer/PHY, on a single clock domain.

## Interface

Parameters:
- `DQ_WIDTH`, 64: DRAM data width; one readback word is `DQ_WIDTH*4` bits, one burst.
- `INSTR_DEPTH_LOG2`, 4: log2 of instruction FIFO depth (16 entries).
- `RDBK_DEPTH_LOG2`, 4: log2 of readback FIFO depth (16 entries).

Ports:
- Clocking and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- `clk` in 1: clock for all logic.
- `rst` in 1: synchronous active-high reset.
- `app_en` in 1: instruction offered by the PCIe application; held until acknowledged.
- `app_instr` in 32: instruction word, stable while `app_en` is high.
- `app_ack` out 1: instruction accepted this cycle.
- `instr_valid` out 1: instruction FIFO not empty.
- `instr_data` out 32: head of instruction FIFO.
- `instr_ready` in 1: sequencer pops the head this cycle.
- `rd_valid` in 1: PHY delivers one read burst this cycle.
- `rd_data` in `DQ_WIDTH*4`: read burst data.
- `rdback_fifo_empty` out 1: readback FIFO empty.
- `rdback_fifo_rden` in 1: PCIe application pops the readback head.
- `rdback_data` out `DQ_WIDTH*4`: head of readback FIFO, valid while not empty.
- `instr_count` out `INSTR_DEPTH_LOG2+1`: instruction FIFO occupancy.
- `rdback_count` out `RDBK_DEPTH_LOG2+1`: readback FIFO occupancy.
- `rdback_overflow` out 1: sticky; a read burst was dropped.

## Operation

- Instruction FIFO: circular buffer, `2**INSTR_DEPTH_LOG2` entries, separate read and write pointers of `INSTR_DEPTH_LOG2` bits that wrap naturally, plus occupancy counter.
- `app_ack = app_en && (instr_count != DEPTH)` is combinational. A transfer occurs on a cycle where `app_en && app_ack`; `app_instr` is written at the write pointer.
- When full, `app_ack` stays low and `app_en` is back-pressured; no instruction is lost. Push is not allowed at full even with a simultaneous pop.
- Pop occurs when `instr_valid && instr_ready`. `instr_ready` while empty is ignored.
- Simultaneous push and pop in one cycle: both pointers advance and the count is unchanged.
- Readback FIFO: same structure, `2**RDBK_DEPTH_LOG2` entries, `DQ_WIDTH*4` wide, first-word-fall-through. `rdback_data` is the combinational read of the head entry.
- Push occurs on `rd_valid`. The PHY cannot be stalled, so if the FIFO is full and no pop happens that cycle, the burst is dropped and `rdback_overflow` is set. If full with a simultaneous pop, the push is accepted.
- Pop occurs on `rdback_fifo_rden && !rdback_fifo_empty`. `rdback_fifo_rden` while empty is ignored and has no pointer movement.
- `rdback_overflow` is cleared only by `rst`.

## Timing

- Reset values: `app_ack` follows its combinational equation (0 unless `app_en`); `instr_valid`=0; `rdback_fifo_empty`=1; both counts 0; `rdback_overflow`=0; pointers 0. FIFO RAM contents are not reset; data outputs are don't-care while empty.
- `rst` asserted mid-operation flushes both FIFOs at that clock edge. Any instruction handshaked in the reset cycle is discarded.
- Latency: a word pushed at edge N is visible at the output (`instr_valid`=1 or `rdback_fifo_empty`=0) after edge N, i.e. one cycle push-to-available. There is no combinational bypass from input to output.
- A pop at edge N presents the next head after edge N.
- Counts and flags are registered. `app_ack` is the only combinational output path from an input (`app_en`).
- Sustained throughput: one push and one pop per cycle on each FIFO.

## Test plan

- Reset, then `app_en`=1 with instructions 0x00000001..0x00000003 on consecutive cycles and `instr_ready`=0 -> `app_ack`=1 each cycle; `instr_count`=3; `instr_data`=0x00000001 starting the cycle after the first push.
- Fill: 17 instructions offered with `instr_ready`=0 -> first 16 acked; `app_ack`=0 with count=16; one pop -> 17th acked on the following cycle; pop order is 1..17 with no loss.
- Simultaneous push/pop at count=5 for 20 cycles -> count stays 5; output order preserved across pointer wrap.
- Readback: `rd_valid` pulses with data 0xA..., 0xB... -> `rdback_fifo_empty` deasserts one cycle after the first pulse; `rdback_data`=0xA...; a `rdback_fifo_rden` pulse -> 0xB... on the next cycle; after the second pop, `rdback_fifo_empty`=1.
- Overflow: 17 `rd_valid` pulses with no pops -> `rdback_count`=16, `rdback_overflow`=1, 17th word absent; `rdback_overflow` stays 1 after draining; `rst` -> 0.
- Reset mid-stream with both FIFOs at count 7 -> next cycle both counts 0, `instr_valid`=0, `rdback_fifo_empty`=1; `rdback_fifo_rden`/`instr_ready` while empty cause no pointer movement.
